// File: rtl/register_file.sv
// register_file: 2R/1W CPU register file with R0 hard-wired to zero, a debug read port
// and a retired-write counter. Define REGFILE_WRITE_BYPASS_EN for write-through forwarding.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RegWre,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic [ADDR_W-1:0] dbgAddr,
  output logic [DATA_W-1:0] dbgData,
  output logic [CNT_W-1:0]  wrCount
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  wr_count_q;
  logic [CNT_W-1:0]  wr_count_d;
  logic              wr_en;
  logic [DATA_W-1:0] rd1_raw;
  logic [DATA_W-1:0] rd2_raw;

  assign wr_en = RegWre && (writeReg != '0);

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (wr_en) begin
      regs_d[writeReg] = writeData;
      wr_count_d       = wr_count_q + CNT_W'(1);
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    rd1_raw = (rs == '0) ? '0 : regs_q[rs];
    rd2_raw = (rt == '0) ? '0 : regs_q[rt];
    dbgData = (dbgAddr == '0) ? '0 : regs_q[dbgAddr];
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  // Forwarding is gated by RST so reads stay zero while reset is held.
  always_comb begin
    readData1 = (RST && wr_en && (writeReg == rs)) ? writeData : rd1_raw;
    readData2 = (RST && wr_en && (writeReg == rt)) ? writeData : rd2_raw;
  end
`else
  always_comb begin
    readData1 = rd1_raw;
    readData2 = rd2_raw;
  end
`endif

  assign wrCount = wr_count_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: scoreboard queue of expected read values,
// checked with immediate assertions after each directed step.
module tb_register_file;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RegWre = 1'b0;
  logic        RegWre4 = 1'b0;
  logic [4:0]  rs = '0, rt = '0, writeReg = '0, dbgAddr = '0;
  logic [31:0] writeData = '0;
  logic [31:0] rd1, rd2, dbg, cnt;
  logic [31:0] s_rd1, s_rd2, s_dbg;
  logic [3:0]  s_cnt;

  always #5 CLK = ~CLK;

  register_file #(.DATA_W(32), .ADDR_W(5), .NREG(32), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .RegWre(RegWre), .rs(rs), .rt(rt), .writeReg(writeReg),
    .writeData(writeData), .readData1(rd1), .readData2(rd2), .dbgAddr(dbgAddr),
    .dbgData(dbg), .wrCount(cnt)
  );

  register_file #(.DATA_W(32), .ADDR_W(5), .NREG(32), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .RegWre(RegWre4), .rs(rs), .rt(rt), .writeReg(writeReg),
    .writeData(writeData), .readData1(s_rd1), .readData2(s_rd2), .dbgAddr(dbgAddr),
    .dbgData(s_dbg), .wrCount(s_cnt)
  );

  typedef struct { string tag; logic [31:0] exp; } exp_t;
  exp_t sb[$];

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] mreg [32];
  int unsigned mcnt;
  logic [3:0]  mcnt4;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    mcnt  = 0;
    mcnt4 = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en, input logic en4);
    @(negedge CLK);
    writeReg  = a;
    writeData = d;
    RegWre    = en;
    RegWre4   = en4;
    @(posedge CLK);
    if (en && a != 5'd0) begin
      mreg[a] = d;
      mcnt++;
    end
    if (en4 && a != 5'd0) mcnt4 = mcnt4 + 4'd1;
    #1;
    RegWre  = 1'b0;
    RegWre4 = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d);
    @(negedge CLK);
    rs = a;
    rt = b;
    dbgAddr = d;
    push({tag, "_rd1"}, mreg[a]);
    push({tag, "_rd2"}, mreg[b]);
    push({tag, "_dbg"}, mreg[d]);
    push({tag, "_cnt"}, mcnt);
    #1;
    chk(rd1);
    chk(rd2);
    chk(dbg);
    chk(cnt);
  endtask

  // RegWre must be known whenever the block is out of reset.
  always @(posedge CLK) begin
    if (RST === 1'b1) begin
      assert (!$isunknown(RegWre)) else begin
        bad++;
        $error("FAIL regwre_x observed=%b expected=0/1", RegWre);
      end
    end
  end

  initial begin
    model_clear();
    rs = 5'd3; rt = 5'd7; dbgAddr = 5'd12;
    #2 RST = 1'b0;
    #1;
    push("rst0_rd1", 32'h0); push("rst0_rd2", 32'h0);
    push("rst0_dbg", 32'h0); push("rst0_cnt", 32'h0);
    chk(rd1); chk(rd2); chk(dbg); chk(cnt);
    @(negedge CLK);
    RST = 1'b1;

    // basic write then read on both ports
    wr(5'd5, 32'h1234_5678, 1'b1, 1'b0);
    rd_check("wr_r5", 5'd5, 5'd5, 5'd5);

    // zero register is never written and never counted
    wr(5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    rd_check("zero", 5'd0, 5'd0, 5'd0);

    // same-cycle read of the register being written
    wr(5'd9, 32'h0000_0011, 1'b1, 1'b0);
    @(negedge CLK);
    rs = 5'd9; rt = 5'd5; dbgAddr = 5'd9;
    writeReg = 5'd9; writeData = 32'hA5A5_A5A5; RegWre = 1'b1;
`ifdef REGFILE_WRITE_BYPASS_EN
    push("byp_rd1", 32'hA5A5_A5A5);
`else
    push("byp_rd1", 32'h0000_0011);
`endif
    push("byp_rd2", 32'h1234_5678);
    push("byp_dbg", 32'h0000_0011);
    #1;
    chk(rd1); chk(rd2); chk(dbg);
    @(posedge CLK);
    mreg[9] = 32'hA5A5_A5A5;
    mcnt++;
    #1 RegWre = 1'b0;
    rd_check("after_byp", 5'd9, 5'd5, 5'd9);

    // repeated write of the same value still counts
    wr(5'd9, 32'hA5A5_A5A5, 1'b1, 1'b0);
    rd_check("rep_wr", 5'd9, 5'd0, 5'd9);

    // asynchronous reset mid-run, observed without any clock edge
    @(negedge CLK);
    rs = 5'd5; rt = 5'd9; dbgAddr = 5'd5;
    #2 RST = 1'b0;
    #1;
    push("mrst_rd1", 32'h0); push("mrst_rd2", 32'h0);
    push("mrst_dbg", 32'h0); push("mrst_cnt", 32'h0);
    chk(rd1); chk(rd2); chk(dbg); chk(cnt);
    model_clear();
    @(negedge CLK);
    RST = 1'b1;

    // full sweep r1..r31
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + 32'(i), 1'b1, 1'b0);
    for (int i = 1; i < 32; i++) rd_check("sweep", 5'(i), 5'(32 - i), 5'(i));
    @(negedge CLK);
    push("sweep_cnt", 32'd31);
    #1 chk(cnt);

    // 4-bit counter instance: wraps through zero at the 16th write
    for (int i = 0; i < 16; i++) wr(5'((i % 31) + 1), 32'(i), 1'b0, 1'b1);
    @(negedge CLK);
    push("wrap16_cnt", 32'(mcnt4));
    push("wrap16_zero", 32'h0);
    #1;
    chk({28'h0, s_cnt});
    chk({28'h0, s_cnt});
    wr(5'd17, 32'h55, 1'b0, 1'b1);
    wr(5'd0, 32'h66, 1'b0, 1'b1);
    @(negedge CLK);
    push("wrap17_cnt", 32'h1);
    push("main_cnt_idle", 32'(mcnt));
    #1;
    chk({28'h0, s_cnt});
    chk(cnt);

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
